// File: rtl/edge_stream_filter_if.sv
`default_nettype none
// ============================================================================
//  Module   : edge_stream_filter_if
//  Brief    : Pixel stream handshake bundle for edge_stream_filter
//  Revision : 1.0  initial release
// ============================================================================
interface edge_stream_filter_if #(
    parameter int CH_W = 8
);
    logic                in_valid;
    logic                in_ready;
    logic                in_sof;
    logic [3*CH_W-1:0]   in_pixel;
    logic [CH_W+2:0]     iThreshold;
    logic                edge_mode;
    logic                mask_en;
    logic                out_valid;
    logic                out_ready;
    logic [3*CH_W-1:0]   out_pixel;
    logic                out_edge;
    logic                out_sof;
    logic                busy;

    modport master (
        output in_valid, in_sof, in_pixel, iThreshold, edge_mode, mask_en, out_ready,
        input  in_ready, out_valid, out_pixel, out_edge, out_sof, busy
    );

    modport slave (
        input  in_valid, in_sof, in_pixel, iThreshold, edge_mode, mask_en, out_ready,
        output in_ready, out_valid, out_pixel, out_edge, out_sof, busy
    );
endinterface
`default_nettype wire

// File: rtl/edge_stream_filter.sv
`default_nettype none
// ============================================================================
//  Module   : edge_stream_filter
//  Brief    : Streaming 3x3 Sobel/Prewitt edge detector with optional masking
//  Revision : 1.0  initial release
// ============================================================================
module edge_stream_filter #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int CH_W       = 8
) (
    input wire                  clk,
    input wire                  rst,
    edge_stream_filter_if.slave bus
);
    localparam int c_PIX_W  = 3 * CH_W;
    localparam int c_GRAD_W = CH_W + 3;
    localparam int c_NPIX   = IMG_WIDTH * IMG_HEIGHT;
    localparam int c_CNT_W  = $clog2(c_NPIX + 1);
    localparam int c_COL_W  = $clog2(IMG_WIDTH);
    localparam int c_ROW_W  = $clog2(IMG_HEIGHT);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_FILL   = 2'd1;
    localparam logic [1:0] c_STREAM = 2'd2;
    localparam logic [1:0] c_FLUSH  = 2'd3;

    localparam logic [c_CNT_W-1:0] c_FILL_LAST = c_CNT_W'(IMG_WIDTH);
    localparam logic [c_CNT_W-1:0] c_IN_LAST   = c_CNT_W'(c_NPIX - 1);
    localparam logic [c_CNT_W-1:0] c_OUT_ALL   = c_CNT_W'(c_NPIX);
    localparam logic [c_COL_W-1:0] c_COL_LAST  = c_COL_W'(IMG_WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST  = c_ROW_W'(IMG_HEIGHT - 1);

    logic [1:0]                r_state;
    logic [c_CNT_W-1:0]        r_in_cnt;
    logic [c_CNT_W-1:0]        r_out_cnt;
    logic [c_COL_W-1:0]        r_col;
    logic [c_COL_W-1:0]        r_ocol;
    logic [c_ROW_W-1:0]        r_orow;
    logic [c_GRAD_W-1:0]       r_thr;
    logic                      r_mode;
    logic                      r_mask;
    logic                      r_out_valid;
    logic [c_PIX_W-1:0]        r_out_pixel;
    logic                      r_out_edge;
    logic                      r_out_sof;
    logic [c_PIX_W-1:0]        r_mid_pix;
    logic [CH_W-1:0]           r_wi [3][2];
    logic [c_PIX_W+CH_W-1:0]   r_lb_a [IMG_WIDTH];
    logic [CH_W-1:0]           r_lb_b [IMG_WIDTH];

    logic                      w_out_free, w_in_ready, w_in_acc, w_sof_acc;
    logic                      w_shift, w_gen, w_border, w_edge;
    logic [c_COL_W-1:0]        w_wr_col, w_col_next;
    logic [CH_W-1:0]           w_in_int, w_a_int, w_b_int;
    logic [c_PIX_W+CH_W-1:0]   w_a_rd;
    logic [c_PIX_W-1:0]        w_a_pix;
    logic signed [c_GRAD_W-1:0] w_k [3][3];
    logic signed [c_GRAD_W-1:0] w_cx_l, w_cx_r, w_cy_t, w_cy_b, w_gx, w_gy;
    logic [c_GRAD_W-1:0]       w_abs_x, w_abs_y, w_mag;

    assign w_out_free = !r_out_valid || bus.out_ready;
    assign w_in_ready = (r_state != c_FLUSH) && w_out_free;
    assign w_in_acc   = bus.in_valid && w_in_ready;
    assign w_sof_acc  = w_in_acc && bus.in_sof;
    assign w_shift    = w_sof_acc ||
                        ((r_state != c_IDLE) && (w_in_acc || ((r_state == c_FLUSH) && w_out_free)));
    assign w_gen      = !w_sof_acc &&
                        (((r_state == c_STREAM) && w_in_acc) ||
                         ((r_state == c_FLUSH) && w_out_free && (r_out_cnt != c_OUT_ALL)));

    // An accepted SOF always restarts the raster at column 0.
    assign w_wr_col   = w_sof_acc ? '0 : r_col;
    assign w_col_next = (w_wr_col == c_COL_LAST) ? '0 : w_wr_col + 1'b1;

    assign w_in_int = CH_W'(({2'b00, bus.in_pixel[3*CH_W-1:2*CH_W]} +
                             {1'b0, bus.in_pixel[2*CH_W-1:CH_W], 1'b0} +
                             {2'b00, bus.in_pixel[CH_W-1:0]}) >> 2);
    assign w_a_rd  = r_lb_a[w_wr_col];
    assign w_a_pix = w_a_rd[c_PIX_W+CH_W-1:CH_W];
    assign w_a_int = w_a_rd[CH_W-1:0];
    assign w_b_int = r_lb_b[w_wr_col];

    // Window as it will look after this advance: columns 0/1 held, column 2 arriving now.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_k[r][0] = $signed({3'b000, r_wi[r][0]});
            w_k[r][1] = $signed({3'b000, r_wi[r][1]});
        end
        w_k[0][2] = $signed({3'b000, w_b_int});
        w_k[1][2] = $signed({3'b000, w_a_int});
        w_k[2][2] = $signed({3'b000, w_in_int});
    end

    assign w_cx_l  = r_mode ? w_k[1][0] : (w_k[1][0] <<< 1);
    assign w_cx_r  = r_mode ? w_k[1][2] : (w_k[1][2] <<< 1);
    assign w_cy_t  = r_mode ? w_k[0][1] : (w_k[0][1] <<< 1);
    assign w_cy_b  = r_mode ? w_k[2][1] : (w_k[2][1] <<< 1);
    assign w_gx    = (w_k[0][2] + w_cx_r + w_k[2][2]) - (w_k[0][0] + w_cx_l + w_k[2][0]);
    assign w_gy    = (w_k[2][0] + w_cy_b + w_k[2][2]) - (w_k[0][0] + w_cy_t + w_k[0][2]);
    assign w_abs_x = w_gx[c_GRAD_W-1] ? c_GRAD_W'(-w_gx) : c_GRAD_W'(w_gx);
    assign w_abs_y = w_gy[c_GRAD_W-1] ? c_GRAD_W'(-w_gy) : c_GRAD_W'(w_gy);
    assign w_mag   = w_abs_x + w_abs_y;

    assign w_border = (r_orow == '0) || (r_orow == c_ROW_LAST) ||
                      (r_ocol == '0) || (r_ocol == c_COL_LAST);
    assign w_edge   = (w_mag > r_thr) && !w_border;

    always_ff @(posedge clk) begin
        if (w_shift) begin
            r_lb_a[w_wr_col] <= {bus.in_pixel, w_in_int};
            r_lb_b[w_wr_col] <= w_a_int;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_col       <= '0;
            r_ocol      <= '0;
            r_orow      <= '0;
            r_thr       <= '0;
            r_mode      <= 1'b0;
            r_mask      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_pixel <= '0;
            r_out_edge  <= 1'b0;
            r_out_sof   <= 1'b0;
            r_mid_pix   <= '0;
            for (int r = 0; r < 3; r++) begin
                r_wi[r][0] <= '0;
                r_wi[r][1] <= '0;
            end
        end else begin
            if (w_shift) begin
                r_col      <= w_col_next;
                r_mid_pix  <= w_a_pix;
                r_wi[0][0] <= r_wi[0][1];
                r_wi[1][0] <= r_wi[1][1];
                r_wi[2][0] <= r_wi[2][1];
                r_wi[0][1] <= w_b_int;
                r_wi[1][1] <= w_a_int;
                r_wi[2][1] <= w_in_int;
            end

            if (w_sof_acc) begin
                r_state     <= c_FILL;
                r_in_cnt    <= c_CNT_W'(1);
                r_out_cnt   <= '0;
                r_ocol      <= '0;
                r_orow      <= '0;
                r_thr       <= bus.iThreshold;
                r_mode      <= bus.edge_mode;
                r_mask      <= bus.mask_en;
                r_out_valid <= 1'b0;
                r_out_sof   <= 1'b0;
            end else begin
                case (r_state)
                    c_IDLE: ;
                    c_FILL: if (w_in_acc) begin
                        r_in_cnt <= r_in_cnt + 1'b1;
                        if (r_in_cnt == c_FILL_LAST) r_state <= c_STREAM;
                    end
                    c_STREAM: if (w_in_acc) begin
                        r_in_cnt <= r_in_cnt + 1'b1;
                        if (r_in_cnt == c_IN_LAST) r_state <= c_FLUSH;
                    end
                    c_FLUSH: if (w_out_free && (r_out_cnt == c_OUT_ALL)) r_state <= c_IDLE;
                    default: r_state <= c_IDLE;
                endcase

                if (w_gen) begin
                    r_out_valid <= 1'b1;
                    r_out_pixel <= (w_edge && r_mask) ? '0 : r_mid_pix;
                    r_out_edge  <= w_edge;
                    r_out_sof   <= (r_out_cnt == '0);
                    r_out_cnt   <= r_out_cnt + 1'b1;
                    if (r_ocol == c_COL_LAST) begin
                        r_ocol <= '0;
                        r_orow <= (r_orow == c_ROW_LAST) ? '0 : r_orow + 1'b1;
                    end else begin
                        r_ocol <= r_ocol + 1'b1;
                    end
                end else if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_pixel = r_out_pixel;
    assign bus.out_edge  = r_out_edge;
    assign bus.out_sof   = r_out_sof;
    assign bus.busy      = (r_state != c_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_edge_stream_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_edge_stream_filter
//  Brief    : Directed self-checking bench for edge_stream_filter on 4x4 frames
//  Revision : 1.0  initial release
// ============================================================================
module tb_edge_stream_filter;
    localparam int c_W = 4;
    localparam int c_H = 4;
    localparam int c_CW = 8;
    localparam int c_N = c_W * c_H;
    localparam int c_BUDGET = 3000;

    logic tb_clk = 1'b0;
    logic rst = 1'b1;
    always #5 tb_clk = ~tb_clk;

    edge_stream_filter_if #(.CH_W(c_CW)) bus ();

    edge_stream_filter #(
        .IMG_WIDTH  (c_W),
        .IMG_HEIGHT (c_H),
        .CH_W       (c_CW)
    ) dut (
        .clk (tb_clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [24:0] stim [$];
    logic [23:0] got_pix [$];
    logic        got_edge [$];
    logic        got_sof [$];
    logic [23:0] fr [c_N];
    logic [23:0] ep [c_N];
    logic        ee [c_N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected outputs: interior pixels take int_edge, borders never flag.
    task automatic build_exp(input bit int_edge, input bit mask);
        for (int i = 0; i < c_N; i++) begin
            int r = i / c_W;
            int c = i % c_W;
            ee[i] = int_edge && (r > 0) && (r < c_H - 1) && (c > 0) && (c < c_W - 1);
            ep[i] = (ee[i] && mask) ? 24'h0 : fr[i];
        end
    endtask

    task automatic load_frame(input int junk);
        for (int i = 0; i < junk; i++) stim.push_back({1'b0, 24'hFFFFFF});
        for (int i = 0; i < c_N; i++) stim.push_back({(i == 0), fr[i]});
    endtask

    task automatic run_stim(input int pin, input int pout);
        int idx = 0;
        int cyc = 0;
        bit hv = 0;
        logic [23:0] hp = '0;
        logic he = 0;
        logic hs = 0;
        got_pix.delete(); got_edge.delete(); got_sof.delete();
        while ((idx < stim.size() || bus.busy) && cyc < c_BUDGET) begin
            @(negedge tb_clk);
            bus.in_valid = (idx < stim.size()) && ($urandom_range(99) < pin);
            bus.in_sof   = (idx < stim.size()) ? stim[idx][24] : 1'b0;
            if (idx < stim.size()) bus.in_pixel = stim[idx][23:0];
            bus.out_ready = ($urandom_range(99) < pout);
            #1;
            if (hv) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_pix", bus.out_pixel, hp);
                check("hold_edge", bus.out_edge, he);
                check("hold_sof", bus.out_sof, hs);
            end
            if (bus.out_valid && bus.out_ready) begin
                got_pix.push_back(bus.out_pixel);
                got_edge.push_back(bus.out_edge);
                got_sof.push_back(bus.out_sof);
            end
            hv = bus.out_valid && !bus.out_ready;
            hp = bus.out_pixel; he = bus.out_edge; hs = bus.out_sof;
            if (bus.in_valid && bus.in_ready) begin
                if (bus.in_sof && idx > 0) begin
                    got_pix.delete(); got_edge.delete(); got_sof.delete();
                end
                idx++;
            end
            cyc++;
        end
        check("cycle_budget", (cyc < c_BUDGET), 1);
        @(negedge tb_clk);
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.out_ready = 1'b0;
        stim.delete();
    endtask

    task automatic check_out(input string name);
        check({name, "_count"}, got_pix.size(), c_N);
        for (int i = 0; i < c_N && i < got_pix.size(); i++) begin
            check($sformatf("%s_pix%0d", name, i), got_pix[i], ep[i]);
            check($sformatf("%s_edge%0d", name, i), got_edge[i], ee[i]);
            check($sformatf("%s_sof%0d", name, i), got_sof[i], (i == 0));
        end
    endtask

    task automatic set_cfg(input logic [10:0] thr, input logic mode, input logic mask);
        bus.iThreshold = thr; bus.edge_mode = mode; bus.mask_en = mask;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 0; bus.in_sof = 0; bus.in_pixel = '0; bus.out_ready = 0;
        set_cfg(11'd50, 1'b0, 1'b1);
        repeat (3) @(negedge tb_clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_out_pixel", bus.out_pixel, 0);
        check("rst_out_edge", bus.out_edge, 0);
        check("rst_out_sof", bus.out_sof, 0);
        rst = 1'b0;

        // Uniform grey frame, preceded by two stray non-SOF pixels to be dropped.
        for (int i = 0; i < c_N; i++) fr[i] = 24'h808080;
        build_exp(1'b0, 1'b1);
        load_frame(2); run_stim(100, 100); check_out("uni");

        // Vertical step: Sobel interior magnitude 800.
        for (int i = 0; i < c_N; i++) fr[i] = ((i % c_W) < 2) ? 24'h000000 : 24'hC8C8C8;
        set_cfg(11'd50, 1'b0, 1'b1);
        build_exp(1'b1, 1'b1);
        load_frame(0); run_stim(100, 100); check_out("sobel");

        // Prewitt interior magnitude 600, threshold is strict greater-than.
        set_cfg(11'd700, 1'b1, 1'b1);
        build_exp(1'b0, 1'b1);
        load_frame(0); run_stim(100, 100); check_out("prw700");
        set_cfg(11'd600, 1'b1, 1'b1);
        load_frame(0); run_stim(100, 100); check_out("prw600");
        set_cfg(11'd599, 1'b1, 1'b1);
        build_exp(1'b1, 1'b1);
        load_frame(0); run_stim(100, 100); check_out("prw599");

        // Horizontal step of a coloured pixel (I=200), bursty input, random backpressure.
        for (int i = 0; i < c_N; i++) fr[i] = ((i / c_W) < 2) ? 24'h000000 : 24'h64FAC8;
        set_cfg(11'd599, 1'b1, 1'b1);
        build_exp(1'b1, 1'b1);
        load_frame(0); run_stim(60, 50); check_out("stall");
        load_frame(0); run_stim(30, 70); check_out("stall2");

        // Frame A aborted after 9 pixels by frame B.
        for (int i = 0; i < 9; i++) stim.push_back({(i == 0), 24'h123456});
        for (int i = 0; i < c_N; i++) fr[i] = ((i % c_W) < 2) ? 24'h000000 : 24'hC8C8C8;
        set_cfg(11'd50, 1'b0, 1'b0);
        build_exp(1'b1, 1'b0);
        load_frame(0); run_stim(100, 100); check_out("abort");

        // Asynchronous reset during STREAM, then a clean frame.
        for (int i = 0; i < c_N; i++) fr[i] = 24'h808080;
        set_cfg(11'd50, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge tb_clk);
            bus.in_valid = 1; bus.in_sof = (i == 0); bus.in_pixel = fr[i]; bus.out_ready = 1;
        end
        @(negedge tb_clk);
        bus.in_valid = 0; bus.in_sof = 0;
        #1;
        check("pre_rst_busy", bus.busy, 1);
        check("pre_rst_out_valid", bus.out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_in_ready", bus.in_ready, 1);
        @(negedge tb_clk);
        rst = 1'b0;
        bus.out_ready = 0;
        build_exp(1'b0, 1'b1);
        load_frame(0); run_stim(100, 100); check_out("post_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
